ifid_skid_reg: RTL

IFID_SKID_REG -- requirements
Module: ifid_skid_reg

---
 rtl/ifid_skid_reg_pkg.sv | 19 +
 rtl/ifid_skid_reg.sv | 127 ++++++++++++
 2 files changed

// File: rtl/ifid_skid_reg_pkg.sv
// Shared pipeline-register package.
// Holds the default field widths and the bubble instruction used by the
// IF/ID register and its ID/EX, EX/MEM and MEM/WB successors, plus the
// occupancy encoding for the two-entry skid registers.
package ifid_skid_reg_pkg;

  localparam int          PIPE_INSWIDTH = 32;
  localparam int          PIPE_AWIDTH   = 32;
  // MIPS sll $0,$0,0: the canonical bubble.
  localparam logic [31:0] PIPE_NOP_INS  = 32'h0000_0000;

  // Encoded as {skid_valid, main_valid} so each flag is a single state bit.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_FULL  = 2'b11
  } skid_state_e;

endpackage

// File: rtl/ifid_skid_reg.sv
// IF/ID pipeline register with a one-entry skid buffer (capacity 2).
// The main register drives the ID stage; the skid register catches the
// entry accepted in the cycle ID stalls, so in_ready can be a pure flop
// output with no combinational path from out_ready.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   flush      drop all held and incoming entries (redirect)
//   in_valid   IF presents {insin, pcnextin}
//   in_ready   block can accept an entry this cycle (registered)
//   insin      fetched instruction
//   pcnextin   PC+4 of the fetched instruction
//   out_valid  ID is offered {insout, pcnextout}
//   out_ready  ID accepts the entry (low = stall)
//   insout     offered instruction, NOP_INS when out_valid=0
//   pcnextout  offered PC+4, holds its last value when out_valid=0
module ifid_skid_reg
  import ifid_skid_reg_pkg::*;
#(
  parameter int                  INSWIDTH = PIPE_INSWIDTH,
  parameter int                  AWIDTH   = PIPE_AWIDTH,
  parameter logic [INSWIDTH-1:0] NOP_INS  = INSWIDTH'(PIPE_NOP_INS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [INSWIDTH-1:0] insin,
  input  logic [AWIDTH-1:0]   pcnextin,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [INSWIDTH-1:0] insout,
  output logic [AWIDTH-1:0]   pcnextout
);

  skid_state_e         state_q, state_d;
  logic [INSWIDTH-1:0] main_ins_q, main_ins_d;
  logic [AWIDTH-1:0]   main_pc_q, main_pc_d;
  logic [INSWIDTH-1:0] skid_ins_q, skid_ins_d;
  logic [AWIDTH-1:0]   skid_pc_q, skid_pc_d;

  logic main_valid;
  logic skid_valid;
  logic in_xfer;
  logic out_xfer;

  assign main_valid = (state_q != ST_EMPTY);
  assign skid_valid = (state_q == ST_FULL);

  // Both handshake outputs come straight from the state flops.
  assign in_ready  = ~skid_valid;
  assign out_valid = main_valid;

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = main_valid & out_ready;

  // Bubble on the instruction field only; PC+4 keeps its last value.
  assign insout    = main_valid ? main_ins_q : NOP_INS;
  assign pcnextout = main_pc_q;

  always_comb begin
    state_d    = state_q;
    main_ins_d = main_ins_q;
    main_pc_d  = main_pc_q;
    skid_ins_d = skid_ins_q;
    skid_pc_d  = skid_pc_q;

    if (flush) begin
      // Redirect wins over everything; data registers keep their contents
      // so pcnextout still holds its last value.
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_xfer) begin
            state_d    = ST_ONE;
            main_ins_d = insin;
            main_pc_d  = pcnextin;
          end
        end
        ST_ONE: begin
          case ({in_xfer, out_xfer})
            2'b11: begin
              main_ins_d = insin;
              main_pc_d  = pcnextin;
            end
            2'b01: state_d = ST_EMPTY;
            2'b10: begin
              // ID stalled while IF delivered: park the new entry.
              state_d    = ST_FULL;
              skid_ins_d = insin;
              skid_pc_d  = pcnextin;
            end
            default: ;
          endcase
        end
        ST_FULL: begin
          if (out_xfer) begin
            state_d    = ST_ONE;
            main_ins_d = skid_ins_q;
            main_pc_d  = skid_pc_q;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_EMPTY;
      main_ins_q <= '0;
      main_pc_q  <= '0;
      skid_ins_q <= '0;
      skid_pc_q  <= '0;
    end else begin
      state_q    <= state_d;
      main_ins_q <= main_ins_d;
      main_pc_q  <= main_pc_d;
      skid_ins_q <= skid_ins_d;
      skid_pc_q  <= skid_pc_d;
    end
  end

endmodule
